// File: rtl/hi_fsk_bit_demod_if.sv
// ---------------------------------------------------------------------------
// hi_fsk_bit_demod_if
//
// Bundles the signals between the HF FSK edge-interval front-end, the
// ISO15693 bit demodulator and the SSP/ARM-side framer.
//
//   period_in     front-end -> demod   edge interval in 13.56 MHz cycles
//   period_valid  front-end -> demod   1-cycle strobe qualifying period_in
//   byte_ready    framer    -> demod   framer accepts byte_out
//   byte_out      demod     -> framer  decoded byte, LSB = first bit
//   byte_valid    demod     -> framer  byte_out holds an unconsumed byte
//   frame_active  demod     -> framer  demodulator is inside a frame
//   frame_end     demod     -> framer  1-cycle pulse when a frame closes
//   frame_err     demod     -> framer  last frame closed on a code violation
//   overrun       demod     -> framer  a decoded byte was dropped
//   partial_bits  demod     -> framer  bits in discarded trailing partial byte
//
// Modports:
//   master - the environment side (front-end plus framer)
//   slave  - the demodulator
// ---------------------------------------------------------------------------
interface hi_fsk_bit_demod_if;
    logic [7:0] period_in;
    logic       period_valid;
    logic       byte_ready;
    logic [7:0] byte_out;
    logic       byte_valid;
    logic       frame_active;
    logic       frame_end;
    logic       frame_err;
    logic       overrun;
    logic [2:0] partial_bits;

    modport master (
        output period_in, period_valid, byte_ready,
        input  byte_out, byte_valid, frame_active, frame_end,
               frame_err, overrun, partial_bits
    );

    modport slave (
        input  period_in, period_valid, byte_ready,
        output byte_out, byte_valid, frame_active, frame_end,
               frame_err, overrun, partial_bits
    );
endinterface

// File: rtl/hi_fsk_bit_demod.sv
// ---------------------------------------------------------------------------
// hi_fsk_bit_demod
//
// ISO15693 two-subcarrier bit demodulator. Each edge interval from the
// front-end is classified as high subcarrier (H, ~28 cycles), low
// subcarrier (L, ~32 cycles) or invalid. Intervals are accumulated until a
// half-bit worth of cycles has elapsed; the half-bit takes the majority
// class of the intervals it contains. A pair of half-bits is Manchester
// decoded (H,L -> 1; L,H -> 0) and bits are packed LSB-first into bytes
// handed to the framer over a valid/ready handshake.
//
// Ports:
//   ck_1356meg  13.56 MHz clock, all logic on its rising edge
//   reset       synchronous, active-high
//   bus         hi_fsk_bit_demod_if.slave (see interface for signal list)
//
// Parameters:
//   THRESH    intervals in [P_MIN, THRESH-1] are H, [THRESH, P_MAX] are L
//   P_MIN     smallest valid interval
//   P_MAX     largest valid interval
//   HALF_CYC  accumulated cycles that close one half-bit
// ---------------------------------------------------------------------------
module hi_fsk_bit_demod #(
    parameter logic [7:0] THRESH   = 8'd30,
    parameter logic [7:0] P_MIN    = 8'd20,
    parameter logic [7:0] P_MAX    = 8'd40,
    parameter logic [9:0] HALF_CYC = 10'd252
) (
    input  logic                  ck_1356meg,
    input  logic                  reset,
    hi_fsk_bit_demod_if.slave     bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_HALF_A,
        S_HALF_B
    } state_t;

    // Per-interval classification.
    typedef enum logic [1:0] {
        C_INV,
        C_H,
        C_L
    } cls_t;

    // Outcome of a half-bit majority vote.
    typedef enum logic [1:0] {
        HB_H,
        HB_L,
        HB_TIE
    } half_t;

    // -----------------------------------------------------------------------
    // Registered state
    // -----------------------------------------------------------------------
    state_t     state;
    logic [9:0] sum;            // cycles accumulated in the current half-bit
    logic [3:0] votes_h;
    logic [3:0] votes_l;
    logic [1:0] inv_run;        // consecutive invalid intervals in a frame
    half_t      half_a;         // outcome of the first half of the bit
    logic [7:0] bit_reg;        // byte under assembly
    logic [2:0] bit_cnt;
    logic       byte_emitted;   // a full byte completed in this frame

    logic [7:0] byte_out_r;
    logic       byte_valid_r;
    logic       frame_active_r;
    logic       frame_end_r;
    logic       frame_err_r;
    logic       overrun_r;
    logic [2:0] partial_bits_r;

    // -----------------------------------------------------------------------
    // Next-state values
    // -----------------------------------------------------------------------
    state_t     state_n;
    logic [9:0] sum_n;
    logic [3:0] votes_h_n;
    logic [3:0] votes_l_n;
    logic [1:0] inv_run_n;
    half_t      half_a_n;
    logic [7:0] bit_reg_n;
    logic [2:0] bit_cnt_n;
    logic       byte_emitted_n;

    logic [7:0] byte_out_n;
    logic       byte_valid_n;
    logic       frame_end_n;
    logic       frame_err_n;
    logic       overrun_n;
    logic [2:0] partial_bits_n;

    // Combinational helpers
    cls_t       cls;
    logic [9:0] sum_acc;
    logic [3:0] votes_h_acc;
    logic [3:0] votes_l_acc;
    half_t      half_cls;
    logic       half_done;
    logic       bit_val;
    logic       close_evt;
    logic       violation;

    // -----------------------------------------------------------------------
    // Interval classification
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal driven here gets a value on every path (defaults
        // first), otherwise synthesis infers a latch to hold the old value.
        cls = C_INV;
        if (bus.period_in >= P_MIN && bus.period_in <= P_MAX) begin
            cls = (bus.period_in < THRESH) ? C_H : C_L;
        end
    end

    // -----------------------------------------------------------------------
    // Half-bit accumulation: what sum and votes would become if this strobe
    // is counted, and whether that closes the half.
    // -----------------------------------------------------------------------
    always_comb begin
        sum_acc     = sum + {2'b00, bus.period_in};
        votes_h_acc = votes_h;
        votes_l_acc = votes_l;
        if (cls == C_H && votes_h != 4'hF) begin
            votes_h_acc = votes_h + 4'd1;
        end
        if (cls == C_L && votes_l != 4'hF) begin
            votes_l_acc = votes_l + 4'd1;
        end

        if (votes_h_acc > votes_l_acc) begin
            half_cls = HB_H;
        end else if (votes_l_acc > votes_h_acc) begin
            half_cls = HB_L;
        end else begin
            half_cls = HB_TIE;
        end

        half_done = (cls != C_INV) && (sum_acc >= HALF_CYC);
    end

    // -----------------------------------------------------------------------
    // Next-state and output logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_n        = state;
        sum_n          = sum;
        votes_h_n      = votes_h;
        votes_l_n      = votes_l;
        inv_run_n      = inv_run;
        half_a_n       = half_a;
        bit_reg_n      = bit_reg;
        bit_cnt_n      = bit_cnt;
        byte_emitted_n = byte_emitted;
        byte_out_n     = byte_out_r;
        // A byte accepted this cycle frees the output register first, so a
        // byte completing in the same cycle can load without an overrun.
        byte_valid_n   = byte_valid_r & ~bus.byte_ready;
        frame_end_n    = 1'b0;
        frame_err_n    = frame_err_r;
        overrun_n      = overrun_r;
        partial_bits_n = partial_bits_r;
        bit_val        = 1'b0;
        close_evt      = 1'b0;
        violation      = 1'b0;

        if (bus.period_valid) begin
            unique case (state)
                S_IDLE: begin
                    // The first valid interval opens the frame and is
                    // already part of the first half-bit.
                    if (cls != C_INV) begin
                        state_n        = S_HALF_A;
                        sum_n          = {2'b00, bus.period_in};
                        votes_h_n      = (cls == C_H) ? 4'd1 : 4'd0;
                        votes_l_n      = (cls == C_L) ? 4'd1 : 4'd0;
                        inv_run_n      = 2'd0;
                        bit_cnt_n      = 3'd0;
                        byte_emitted_n = 1'b0;
                        frame_err_n    = 1'b0;
                    end
                end

                S_HALF_A, S_HALF_B: begin
                    if (cls == C_INV) begin
                        // Two invalid intervals in a row mean the carrier
                        // has gone: that is the end of the frame.
                        inv_run_n = inv_run + 2'd1;
                        if (inv_run == 2'd1) begin
                            close_evt = 1'b1;
                        end
                    end else begin
                        inv_run_n = 2'd0;
                        sum_n     = sum_acc;
                        votes_h_n = votes_h_acc;
                        votes_l_n = votes_l_acc;

                        if (half_done) begin
                            // Any overshoot past HALF_CYC is discarded.
                            sum_n     = 10'd0;
                            votes_h_n = 4'd0;
                            votes_l_n = 4'd0;

                            if (state == S_HALF_A) begin
                                half_a_n = half_cls;
                                state_n  = S_HALF_B;
                            end else if (half_a == HB_H && half_cls == HB_L) begin
                                bit_val = 1'b1;
                            end else if (half_a == HB_L && half_cls == HB_H) begin
                                bit_val = 1'b0;
                            end else begin
                                violation = 1'b1;
                                close_evt = 1'b1;
                            end

                            if (state == S_HALF_B && !violation) begin
                                state_n            = S_HALF_A;
                                bit_reg_n[bit_cnt] = bit_val;
                                bit_cnt_n          = bit_cnt + 3'd1;
                                if (bit_cnt == 3'd7) begin
                                    byte_emitted_n = 1'b1;
                                    if (byte_valid_n) begin
                                        overrun_n = 1'b1;
                                    end else begin
                                        byte_out_n   = bit_reg_n;
                                        byte_valid_n = 1'b1;
                                    end
                                end
                            end
                        end
                    end
                end

                default: begin
                    state_n = S_IDLE;
                end
            endcase
        end

        if (close_evt) begin
            state_n        = S_IDLE;
            frame_end_n    = 1'b1;
            partial_bits_n = bit_cnt;
            // Silence after whole bytes is a clean EOF; a violation is only
            // an error once the frame has carried some data.
            frame_err_n    = violation && (bit_cnt != 3'd0 || byte_emitted);
            bit_cnt_n      = 3'd0;
            sum_n          = 10'd0;
            votes_h_n      = 4'd0;
            votes_l_n      = 4'd0;
            inv_run_n      = 2'd0;
        end
    end

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge ck_1356meg) begin
        // NOTE: the reset here is synchronous, so it sits inside the clocked
        // branch and the sensitivity list holds only the clock edge.
        if (reset) begin
            state          <= S_IDLE;
            sum            <= 10'd0;
            votes_h        <= 4'd0;
            votes_l        <= 4'd0;
            inv_run        <= 2'd0;
            half_a         <= HB_TIE;
            bit_reg        <= 8'h00;
            bit_cnt        <= 3'd0;
            byte_emitted   <= 1'b0;
            byte_out_r     <= 8'h00;
            byte_valid_r   <= 1'b0;
            frame_active_r <= 1'b0;
            frame_end_r    <= 1'b0;
            frame_err_r    <= 1'b0;
            overrun_r      <= 1'b0;
            partial_bits_r <= 3'd0;
        end else begin
            // NOTE: non-blocking assignments make every register sample its
            // next value at the same edge, independent of statement order.
            state          <= state_n;
            sum            <= sum_n;
            votes_h        <= votes_h_n;
            votes_l        <= votes_l_n;
            inv_run        <= inv_run_n;
            half_a         <= half_a_n;
            bit_reg        <= bit_reg_n;
            bit_cnt        <= bit_cnt_n;
            byte_emitted   <= byte_emitted_n;
            byte_out_r     <= byte_out_n;
            byte_valid_r   <= byte_valid_n;
            frame_active_r <= (state_n != S_IDLE);
            frame_end_r    <= frame_end_n;
            frame_err_r    <= frame_err_n;
            overrun_r      <= overrun_n;
            partial_bits_r <= partial_bits_n;
        end
    end

    assign bus.byte_out     = byte_out_r;
    assign bus.byte_valid   = byte_valid_r;
    assign bus.frame_active = frame_active_r;
    assign bus.frame_end    = frame_end_r;
    assign bus.frame_err    = frame_err_r;
    assign bus.overrun      = overrun_r;
    assign bus.partial_bits = partial_bits_r;

endmodule

// File: tb/tb_hi_fsk_bit_demod.sv
// ---------------------------------------------------------------------------
// tb_hi_fsk_bit_demod
//
// Directed bench for hi_fsk_bit_demod. Stimulus pushes the bytes and frame
// closures it expects into queues; a monitor on the falling clock edge pops
// and compares whenever a byte is handed over or a frame_end pulse appears.
// ---------------------------------------------------------------------------
module tb_hi_fsk_bit_demod;

    logic ck_1356meg = 1'b0;
    logic reset      = 1'b1;

    hi_fsk_bit_demod_if bus ();

    hi_fsk_bit_demod dut (
        .ck_1356meg (ck_1356meg),
        .reset      (reset),
        .bus        (bus)
    );

    always #5 ck_1356meg = ~ck_1356meg;

    typedef struct packed {
        logic [2:0] pb;
        logic       err;
    } frame_t;

    logic [7:0] exp_bytes[$];
    frame_t     exp_frames[$];

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // -----------------------------------------------------------------------
    // Monitor: compares handed-over bytes and frame closures
    // -----------------------------------------------------------------------
    always @(negedge ck_1356meg) begin
        if (!reset) begin
            if (bus.byte_valid && bus.byte_ready) begin
                if (exp_bytes.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_byte: got 0x%0h expected none", bus.byte_out);
                end else begin
                    check("byte_out", {24'd0, bus.byte_out}, {24'd0, exp_bytes.pop_front()});
                end
            end
            if (bus.frame_end) begin
                if (exp_frames.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_frame_end: got pulse expected none");
                end else begin
                    frame_t f;
                    f = exp_frames.pop_front();
                    check("frame_partial_bits", {29'd0, bus.partial_bits}, {29'd0, f.pb});
                    check("frame_err", {31'd0, bus.frame_err}, {31'd0, f.err});
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Stimulus helpers
    // -----------------------------------------------------------------------
    task automatic strobe(input logic [7:0] p);
        bus.period_in    = p;
        bus.period_valid = 1'b1;
        @(posedge ck_1356meg);
        #1;
        bus.period_valid = 1'b0;
        bus.period_in    = 8'd0;
    endtask

    // One half-bit of nominal periods (28 for H, 32 for L) until at least
    // 252 cycles are covered; with corrupt set the first period is a
    // wrong-class 33 (in an H half) or 27 (in an L half).
    task automatic send_half(input bit is_h, input bit corrupt);
        int         s;
        bit         first;
        logic [7:0] p;
        s     = 0;
        first = 1'b1;
        while (s < 252) begin
            p = is_h ? 8'd28 : 8'd32;
            if (corrupt && first) p = is_h ? 8'd33 : 8'd27;
            first = 1'b0;
            strobe(p);
            s += int'(p);
        end
    endtask

    task automatic send_bit(input bit b, input bit corrupt);
        if (b) begin
            send_half(1'b1, corrupt);
            send_half(1'b0, corrupt);
        end else begin
            send_half(1'b0, corrupt);
            send_half(1'b1, corrupt);
        end
    endtask

    task automatic send_byte(input logic [7:0] v, input bit corrupt, input bit expect_it);
        if (expect_it) exp_bytes.push_back(v);
        for (int i = 0; i < 8; i++) send_bit(v[i], corrupt);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((exp_bytes.size() != 0 || exp_frames.size() != 0) && n < 200) begin
            @(posedge ck_1356meg);
            #1;
            n++;
        end
        check({name, "_bytes_left"}, exp_bytes.size(), 0);
        check({name, "_frames_left"}, exp_frames.size(), 0);
    endtask

    // -----------------------------------------------------------------------
    // Directed tests
    // -----------------------------------------------------------------------
    initial begin
        bus.period_in    = 8'd0;
        bus.period_valid = 1'b0;
        bus.byte_ready   = 1'b0;
        repeat (3) @(posedge ck_1356meg);
        #1;
        reset = 1'b0;

        check("rst_byte_out", {24'd0, bus.byte_out}, 32'h00);
        check("rst_byte_valid", {31'd0, bus.byte_valid}, 0);
        check("rst_frame_active", {31'd0, bus.frame_active}, 0);
        check("rst_overrun", {31'd0, bus.overrun}, 0);
        check("rst_partial_bits", {29'd0, bus.partial_bits}, 0);

        // 1: clean 0xA5 followed by two silence strobes
        bus.byte_ready = 1'b1;
        exp_frames.push_back('{pb: 3'd0, err: 1'b0});
        strobe(8'd28);
        check("t1_frame_active_rise", {31'd0, bus.frame_active}, 1);
        send_half(1'b1, 1'b0);   // remaining part of half A has 9 more periods
        // The extra 28 above shifted the first half; restart cleanly instead.
        reset = 1'b1;
        @(posedge ck_1356meg);
        #1;
        reset = 1'b0;
        exp_frames.delete();
        exp_frames.push_back('{pb: 3'd0, err: 1'b0});
        send_byte(8'hA5, 1'b0, 1'b1);
        check("t1_byte_valid_latency", {31'd0, bus.byte_valid}, 1);
        check("t1_byte_out_direct", {24'd0, bus.byte_out}, 32'hA5);
        strobe(8'd0);
        check("t1_one_inv_keeps_frame", {31'd0, bus.frame_active}, 1);
        strobe(8'd0);
        check("t1_frame_active_fall", {31'd0, bus.frame_active}, 0);
        check("t1_frame_end_pulse", {31'd0, bus.frame_end}, 1);
        drain("t1");

        // 2: 0xA5 with one minority wrong-class period in every half
        exp_frames.push_back('{pb: 3'd0, err: 1'b0});
        send_byte(8'hA5, 1'b1, 1'b1);
        strobe(8'd0);
        strobe(8'd0);
        drain("t2");

        // 3: two bytes with the consumer stalled -> second byte dropped
        bus.byte_ready = 1'b0;
        exp_frames.push_back('{pb: 3'd0, err: 1'b0});
        send_byte(8'h3C, 1'b0, 1'b1);
        check("t3_overrun_clear", {31'd0, bus.overrun}, 0);
        send_byte(8'h81, 1'b0, 1'b0);
        strobe(8'd0);
        strobe(8'd0);
        check("t3_byte_held", {24'd0, bus.byte_out}, 32'h3C);
        check("t3_byte_valid_held", {31'd0, bus.byte_valid}, 1);
        check("t3_overrun", {31'd0, bus.overrun}, 1);
        bus.byte_ready = 1'b1;
        @(posedge ck_1356meg);
        #1;
        check("t3_byte_valid_drop", {31'd0, bus.byte_valid}, 0);
        drain("t3");

        // 4: 11 bits then an L,L half pair -> violation with data
        exp_frames.push_back('{pb: 3'd3, err: 1'b1});
        send_byte(8'h4B, 1'b0, 1'b1);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        send_half(1'b0, 1'b0);
        send_half(1'b0, 1'b0);
        check("t4_frame_end", {31'd0, bus.frame_end}, 1);
        check("t4_partial_bits", {29'd0, bus.partial_bits}, 3);
        check("t4_frame_err", {31'd0, bus.frame_err}, 1);
        check("t4_frame_active", {31'd0, bus.frame_active}, 0);
        drain("t4");

        // 5: noise in IDLE changes nothing
        strobe(8'd0);
        @(posedge ck_1356meg);
        #1;
        strobe(8'd5);
        strobe(8'd90);
        repeat (2) @(posedge ck_1356meg);
        #1;
        check("t5_frame_active", {31'd0, bus.frame_active}, 0);
        check("t5_byte_valid", {31'd0, bus.byte_valid}, 0);
        check("t5_byte_out", {24'd0, bus.byte_out}, 32'h4B);
        check("t5_frame_err_sticky", {31'd0, bus.frame_err}, 1);
        check("t5_partial_bits", {29'd0, bus.partial_bits}, 3);

        // 6: reset after 4 bits, then a fresh frame
        send_bit(1'b1, 1'b0);
        check("t6_frame_err_cleared", {31'd0, bus.frame_err}, 0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        check("t6_mid_frame", {31'd0, bus.frame_active}, 1);
        reset = 1'b1;
        @(posedge ck_1356meg);
        #1;
        reset = 1'b0;
        check("t6_rst_byte_out", {24'd0, bus.byte_out}, 32'h00);
        check("t6_rst_overrun", {31'd0, bus.overrun}, 0);
        check("t6_rst_partial_bits", {29'd0, bus.partial_bits}, 0);
        check("t6_rst_frame_active", {31'd0, bus.frame_active}, 0);
        check("t6_rst_frame_end", {31'd0, bus.frame_end}, 0);
        exp_frames.push_back('{pb: 3'd0, err: 1'b0});
        send_byte(8'hA5, 1'b0, 1'b1);
        strobe(8'd0);
        strobe(8'd0);
        drain("t6");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/hi_fsk_bit_demod.md
# hi_fsk_bit_demod

Consumes the stream of edge-interval bytes (13.56 MHz cycles between subcarrier edges) produced by the HF FSK reader front-end and turns it into ISO15693 two-subcarrier data bytes. Each period is classified as high subcarrier (484.28 kHz, ~28 cycles) or low subcarrier (423.75 kHz, ~32 cycles). Periods are grouped into half-bits by cycle accumulation, half-bits are decided by majority vote, and bit pairs are Manchester-decoded. Bits are packed LSB-first into bytes delivered over a valid/ready handshake to the SSP/ARM-side framer.

## Interface
- THRESH, 30: periods in [P_MIN, THRESH-1] are class H; periods in [THRESH, P_MAX] are class L.
- P_MIN, 20: smallest valid period.
- P_MAX, 40: largest valid period.
- HALF_CYC, 252: accumulated cycles that close one half-bit.

Ports:
- ck_1356meg  in  1  13.56 MHz clock; all logic on its posedge.
- reset  in  1  synchronous, active-high.
- period_in  in  8  edge interval in cycles; 0 means no carrier/silence.
- period_valid  in  1  1-cycle strobe qualifying period_in.
- byte_ready  in  1  consumer accepts byte_out when byte_valid=1.
- byte_out  out  8  decoded byte, LSB = first received bit.
- byte_valid  out  1  byte_out holds an unconsumed byte.
- frame_active  out  1  demodulator is inside a frame.
- frame_end  out  1  1-cycle pulse when a frame closes.
- frame_err  out  1  sticky until the next frame start; the frame closed on a code violation.
- overrun  out  1  sticky until reset; a byte was dropped.
- partial_bits  out  3  bits in the discarded trailing partial byte; valid on frame_end.

## Operation
- Classification, per strobe: H, L, or INV (0, <P_MIN, >P_MAX).
- States: IDLE, HALF_A, HALF_B.
- IDLE:
  - First H or L strobe: enter HALF_A with that period counted; frame_active=1; clear frame_err.
  - INV strobes are ignored.
- HALF_A / HALF_B:
  - Per strobe: sum(10 bits) += period_in; votes_h or votes_l (4 bits each, saturating at 15) += 1.
  - INV adds nothing and increments inv_run; any H or L strobe clears inv_run.
  - Half closes on the strobe where sum ≥ HALF_CYC. Sum and votes then clear to 0; no remainder carry.
  - Half class is the majority of votes_h vs votes_l. A tie is a violation.
- Bit decode at the HALF_B close:
  - A=H, B=L → 1.
  - A=L, B=H → 0.
  - A=B or either half tied → violation.
  - Decoded bit: shift into the bit register at position bit_cnt; return to HALF_A.
- Byte completion:
  - 8th bit completes a byte: load byte_out and set byte_valid.
  - If byte_valid is still 1 at that point, byte_out is kept, the new byte is dropped and overrun=1.
- Frame close (→ IDLE):
  - Triggers: violation, or inv_run reaching 2.
  - Actions: frame_end pulse; partial_bits = bit_cnt; frame_err=1 only when the close is a violation with bit_cnt≠0 or with a byte already emitted in this frame.
  - Silence after whole bytes is the normal EOF.
  - bit_cnt and sum clear on close; a pending byte_valid is kept.
- Handshake: byte_valid stays high until a cycle with byte_valid & byte_ready; it drops the next cycle.
- Reset: state IDLE; all counters 0; all outputs 0 (byte_out=0x00, partial_bits=0).

## Timing
- All outputs are registered.
- byte_valid and byte_out update 1 cycle after the period_valid strobe that completes the 8th bit.
- frame_end, frame_err and partial_bits update 1 cycle after the closing strobe. frame_active falls in the same cycle.
- frame_active rises 1 cycle after the opening strobe.
- Accept and new byte in the same cycle: the accept wins first, the new byte loads, byte_valid stays 1, no overrun.
- Strobes spaced ≥1 cycle apart; back-to-back strobes on consecutive cycles are legal.
- reset asserted mid-frame: next cycle all state is at reset values and no frame_end is issued.
- Sum width: max 251+255=506 fits 10 bits; no wrap.

## Test plan
- Byte 0xA5, bit 1 = 9×28 then 8×32, bit 0 = 8×32 then 9×28, followed by 2×period 0 → byte_out=0xA5, byte_valid 1 cycle after the 8th bit's last strobe; frame_end with partial_bits=0, frame_err=0.
- Same as 0xA5 but one period in each half replaced by 33/27 (minority wrong class) → still 0xA5.
- Two bytes 0x3C, 0x81 with byte_ready held low → first byte 0x3C held, overrun=1; raise byte_ready → 0x3C accepted, byte_valid drops next cycle.
- 11 bits, then a half pair L,L → frame_end, partial_bits=3, frame_err=1, one byte emitted.
- Noise strobes 0, 5, 90 in IDLE → stays IDLE, no outputs change.
- reset pulsed after 4 bits → all outputs 0; a fresh 0xA5 frame then decodes correctly.
